spi_slave_ctrl: RTL

SPI slave protocol sequencer in the `sck` domain of `ip_spi`. It deserialises command and address from `mosi` and generates the load strobes that drive the read buffer (`addr_load`, `read_load`, `spi_raddr`). It shifts returned read data out on `miso` and produces burst write strobes toward the register file. Frames use SPI mode 0, MSB first, with one frame per `csn` low period.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_ctrl_if.sv | 29 ++
 rtl/spi_shift_out.sv | 28 ++
 rtl/spi_slave_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave sequencer: default opcodes, dummy length
// and the frame state encoding.
package spi_pkg;

    localparam logic [7:0] CMD_WR_DEFAULT = 8'h02;
    localparam logic [7:0] CMD_RD_DEFAULT = 8'h03;
    localparam int         DUMMY_DEFAULT  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RDUMMY,
        RDATA,
        WDATA,
        DROP
    } spi_state_e;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Bus-side signals of the SPI slave sequencer: serial pins, read-buffer strobes
// and the register-file write port.
interface spi_slave_ctrl_if;

    logic        csn;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        addr_load;
    logic        read_load;
    logic [15:0] spi_raddr;
    logic [15:0] spi_rdata;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    modport slave (
        input  csn, mosi, spi_rdata,
        output miso, miso_oe, addr_load, read_load, spi_raddr,
               wr_en, wr_addr, wr_data
    );

    modport master (
        output csn, mosi, spi_rdata,
        input  miso, miso_oe, addr_load, read_load, spi_raddr,
               wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/spi_shift_out.sv
// Negedge-clocked 16-bit MSB-first output shifter; holds zero whenever it is
// neither loading nor shifting so miso idles low.
module spi_shift_out (
    input  logic        sck,
    input  logic        rstn,
    input  logic        i_load,
    input  logic        i_shift,
    input  logic [15:0] i_data,
    output logic        o_miso
);

    logic [15:0] r_shift;

    always_ff @(negedge sck or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= {r_shift[14:0], 1'b0};
        end else begin
            r_shift <= '0;
        end
    end

    assign o_miso = r_shift[15];

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave sequencer: decodes command/address, paces read-buffer
// prefetch strobes, and turns write bursts into register-file strobes.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter logic [7:0] CMD_WR = CMD_WR_DEFAULT,
    parameter logic [7:0] CMD_RD = CMD_RD_DEFAULT,
    parameter int         DUMMY  = DUMMY_DEFAULT
) (
    input  logic            sck,
    input  logic            rstn,
    spi_slave_ctrl_if.slave bus
);

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY - 1);

    spi_state_e  r_state;
    spi_state_e  w_stateNext;
    logic [3:0]  r_bitCnt;
    logic [3:0]  w_bitCntNext;
    logic [14:0] r_shiftIn;
    logic [15:0] w_shiftNext;
    logic        r_isRead;
    logic        w_isReadNext;
    logic        r_addrLoad;
    logic        r_readLoad;
    logic        r_wrEn;
    logic        w_addrLoadNext;
    logic        w_readLoadNext;
    logic        w_wrEnNext;
    logic        w_raddrLd;
    logic        w_ptrLd;
    logic [15:0] r_raddr;
    logic [15:0] r_wrPtr;
    logic [15:0] r_wrAddr;
    logic [15:0] r_wrData;
    logic        w_frameRstn;
    logic        w_shLoad;
    logic        w_shEn;

    // csn high aborts the frame asynchronously; held address/data registers only follow rstn
    assign w_frameRstn = rstn & ~bus.csn;
    assign w_shiftNext = {r_shiftIn, bus.mosi};

    always_ff @(posedge sck or negedge w_frameRstn) begin
        if (!w_frameRstn) begin
            r_state    <= IDLE;
            r_bitCnt   <= '0;
            r_shiftIn  <= '0;
            r_isRead   <= 1'b0;
            r_addrLoad <= 1'b0;
            r_readLoad <= 1'b0;
            r_wrEn     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_bitCnt   <= w_bitCntNext;
            r_shiftIn  <= w_shiftNext[14:0];
            r_isRead   <= w_isReadNext;
            r_addrLoad <= w_addrLoadNext;
            r_readLoad <= w_readLoadNext;
            r_wrEn     <= w_wrEnNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_bitCntNext   = r_bitCnt + 4'd1;
        w_isReadNext   = r_isRead;
        w_addrLoadNext = 1'b0;
        w_readLoadNext = 1'b0;
        w_wrEnNext     = 1'b0;
        w_raddrLd      = 1'b0;
        w_ptrLd        = 1'b0;
        case (r_state)
            // The first posedge of a frame already carries command bit 0
            IDLE: begin
                w_stateNext = CMD;
            end
            CMD: begin
                if (r_bitCnt == 4'd7) begin
                    w_bitCntNext = '0;
                    if (w_shiftNext[7:0] == CMD_RD) begin
                        w_isReadNext = 1'b1;
                        w_stateNext  = ADDR;
                    end else if (w_shiftNext[7:0] == CMD_WR) begin
                        w_isReadNext = 1'b0;
                        w_stateNext  = ADDR;
                    end else begin
                        w_stateNext = DROP;
                    end
                end
            end
            ADDR: begin
                if (r_bitCnt == 4'd15) begin
                    w_bitCntNext = '0;
                    if (r_isRead) begin
                        w_stateNext    = RDUMMY;
                        w_raddrLd      = 1'b1;
                        w_addrLoadNext = 1'b1;
                    end else begin
                        w_stateNext = WDATA;
                        w_ptrLd     = 1'b1;
                    end
                end
            end
            RDUMMY: begin
                if (r_bitCnt == DUMMY_LAST) begin
                    w_bitCntNext = '0;
                    w_stateNext  = RDATA;
                end
            end
            // Bit counter wraps 15->0 on its own, marking each new word
            RDATA: begin
                if (r_bitCnt == 4'd7) begin
                    w_readLoadNext = 1'b1;
                end
            end
            WDATA: begin
                if (r_bitCnt == 4'd15) begin
                    w_wrEnNext = 1'b1;
                end
            end
            DROP: begin
                w_bitCntNext = r_bitCnt;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge sck or negedge rstn) begin
        if (!rstn) begin
            r_raddr  <= '0;
            r_wrPtr  <= '0;
            r_wrAddr <= '0;
            r_wrData <= '0;
        end else begin
            if (w_raddrLd) begin
                r_raddr <= w_shiftNext;
            end
            if (w_ptrLd) begin
                r_wrPtr <= w_shiftNext;
            end else if (w_wrEnNext) begin
                r_wrPtr <= r_wrPtr + 16'd2;
            end
            if (w_wrEnNext) begin
                r_wrAddr <= r_wrPtr;
                r_wrData <= w_shiftNext;
            end
        end
    end

    // Each word is loaded on the negedge right after the counter returns to zero
    assign w_shLoad = (r_state == RDATA) && (r_bitCnt == 4'd0);
    assign w_shEn   = (r_state == RDATA);

    spi_shift_out u_shiftOut (
        .sck     (sck),
        .rstn    (rstn),
        .i_load  (w_shLoad),
        .i_shift (w_shEn),
        .i_data  (bus.spi_rdata),
        .o_miso  (bus.miso)
    );

    assign bus.miso_oe   = (r_state == RDUMMY) || (r_state == RDATA);
    assign bus.addr_load = r_addrLoad;
    assign bus.read_load = r_readLoad;
    assign bus.spi_raddr = r_raddr;
    assign bus.wr_en     = r_wrEn;
    assign bus.wr_addr   = r_wrAddr;
    assign bus.wr_data   = r_wrData;

endmodule
